// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types and constants.
package rv32i_types;

  // Canonical NOP (addi x0, x0, 0), also used for ID/EX bubble insertion.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  // Fetch-stage FSM states, exposed so debug monitors can decode them.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read handshake between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_pc_register.sv
// 32-bit loadable register with synchronous reset to a parameter value.
module pc_register #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Reset has priority over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, the imem read handshake,
// the IF/ID pipeline register and a single-entry skid buffer.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_instr
);

  fetch_state_t state_q;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic         pc_load;
  logic [31:0]  stale_pc;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_instr;

  // PC advances on an accepted FETCH response; a flush overrides with the target.
  always_comb begin
    pc_load = flush || (state_q == FETCH && imem.imem_resp);
    pc_next = flush ? align_word(redirect_pc) : pc + 32'd4;
  end

  pc_register #(
    .RESET_VALUE(RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_next),
    .q   (pc)
  );

  // Read request is combinational from state; DISCARD keeps the abandoned address stable.
  always_comb begin
    imem.imem_read    = 1'b0;
    imem.imem_address = pc;
    if (!rst && state_q != HOLD) begin
      imem.imem_read = 1'b1;
    end
    if (state_q == DISCARD) begin
      imem.imem_address = stale_pc;
    end
  end

  // FSM plus IF/ID, skid and stale-address registers; flush outranks stall and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      skid_pc     <= '0;
      skid_instr  <= NOP_INSTR;
      stale_pc    <= '0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      skid_pc     <= '0;
      skid_instr  <= NOP_INSTR;
      case (state_q)
        FETCH: begin
          if (!imem.imem_resp) begin
            stale_pc <= pc;
            state_q  <= DISCARD;
          end
        end
        HOLD: begin
          state_q <= FETCH;
        end
        DISCARD: begin
          if (imem.imem_resp) begin
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_resp) begin
            if (stall) begin
              skid_pc    <= pc;
              skid_instr <= imem.imem_rdata;
              state_q    <= HOLD;
            end else begin
              if_id_valid <= 1'b1;
              if_id_pc    <= pc;
              if_id_instr <= imem.imem_rdata;
            end
          end else if (!stall) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= skid_pc;
            if_id_instr <= skid_instr;
            skid_pc     <= '0;
            skid_instr  <= NOP_INSTR;
            state_q     <= FETCH;
          end
        end
        DISCARD: begin
          if (imem.imem_resp) begin
            state_q <= FETCH;
          end
          if (!stall) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences and a randomized run against a fetch-stream model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int vectors = 0;
  int miscompares = 0;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(32'h0000_0060)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem       (bus),
    .if_id_valid(if_id_valid),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] redir;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        chk_pc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic s, input logic f, input logic [31:0] rp,
                              input logic rs, input logic [31:0] rd,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic cp, input logic [31:0] ep,
                              input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.flush = f; v.redir = rp; v.resp = rs; v.rdata = rd;
    v.e_read = er; v.e_addr = ea; v.e_valid = ev; v.chk_pc = cp;
    v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  // Instruction memory contents in the randomized run: a fixed function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] rp,
                       input logic rs, input logic [31:0] rd);
    @(negedge clk);
    rst = r; stall = s; flush = f; redirect_pc = rp;
    bus.imem_resp = rs; bus.imem_rdata = rd;
    #1;
  endtask

  task automatic chk_if(input string name, input logic v, input logic [31:0] p, input logic [31:0] i);
    check({name, "_valid"}, if_id_valid, v);
    check({name, "_pc"}, if_id_pc, p);
    check({name, "_instr"}, if_id_instr, i);
  endtask

  task automatic chk_req(input string name, input logic r, input logic [31:0] a);
    check({name, "_read"}, bus.imem_read, r);
    if (r) check({name, "_addr"}, bus.imem_address, a);
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("rst_read", bus.imem_read, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    check("rst_read2", bus.imem_read, 1'b0);
    chk_if("rst_state", 1'b0, 32'h0, NOP);
  endtask

  // Randomized-run model state
  logic [31:0] exp_next;
  logic        p_stall, p_flush, p_pending, p_valid;
  logic [31:0] p_addr, p_pc, p_instr;
  int          mem_wait;
  int          consumed;

  initial begin
    bus.imem_resp  = 1'b0;
    bus.imem_rdata = '0;

    // ---------------- table-driven directed vectors ----------------
    tbl[0]  = mk(0, 0, 32'h0,   1, 32'hAAAA_0001, 1, 32'h60,  0, 1, 32'h0,  NOP);
    tbl[1]  = mk(0, 0, 32'h0,   1, 32'hBBBB_0002, 1, 32'h64,  1, 1, 32'h60, 32'hAAAA_0001);
    tbl[2]  = mk(0, 0, 32'h0,   1, 32'hCCCC_0003, 1, 32'h68,  1, 1, 32'h64, 32'hBBBB_0002);
    tbl[3]  = mk(1, 0, 32'h0,   1, 32'hDDDD_0004, 1, 32'h6C,  1, 1, 32'h68, 32'hCCCC_0003);
    tbl[4]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h0,   1, 1, 32'h68, 32'hCCCC_0003);
    tbl[5]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h0,   1, 1, 32'h68, 32'hCCCC_0003);
    tbl[6]  = mk(0, 0, 32'h0,   0, 32'h0,         0, 32'h0,   1, 1, 32'h68, 32'hCCCC_0003);
    tbl[7]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h70,  1, 1, 32'h6C, 32'hDDDD_0004);
    tbl[8]  = mk(0, 0, 32'h0,   1, 32'hEEEE_0005, 1, 32'h70,  0, 0, 32'h0,  NOP);
    tbl[9]  = mk(1, 1, 32'h203, 1, 32'hFFFF_0006, 1, 32'h74,  1, 1, 32'h70, 32'hEEEE_0005);
    tbl[10] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h200, 0, 1, 32'h0,  NOP);
    tbl[11] = mk(0, 0, 32'h0,   1, 32'h1234_0007, 1, 32'h200, 0, 0, 32'h0,  NOP);
    tbl[12] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h204, 1, 1, 32'h200, 32'h1234_0007);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].resp, tbl[i].rdata);
      check($sformatf("t%0d_read", i), bus.imem_read, tbl[i].e_read);
      if (tbl[i].e_read) check($sformatf("t%0d_addr", i), bus.imem_address, tbl[i].e_addr);
      check($sformatf("t%0d_valid", i), if_id_valid, tbl[i].e_valid);
      if (tbl[i].chk_pc) check($sformatf("t%0d_pc", i), if_id_pc, tbl[i].e_pc);
      check($sformatf("t%0d_instr", i), if_id_instr, tbl[i].e_instr);
    end

    // ---------------- flush with a 3-cycle request outstanding ----------------
    do_reset();
    drive(0, 0, 0, '0, 0, '0);             chk_req("fa0", 1, 32'h60);
    drive(0, 0, 0, '0, 0, '0);             chk_req("fa1", 1, 32'h60);
    drive(0, 0, 0, '0, 1, 32'hAAAA_0001);  chk_req("fa2", 1, 32'h60);
    drive(0, 0, 1, 32'h203, 0, '0);        chk_req("fa3", 1, 32'h64);
    chk_if("fa3", 1, 32'h60, 32'hAAAA_0001);
    drive(0, 0, 0, '0, 0, '0);             chk_req("fa4", 1, 32'h64);
    chk_if("fa4", 0, 32'h0, NOP);
    drive(0, 0, 0, '0, 1, 32'hBAD0_0BAD);  chk_req("fa5", 1, 32'h64);
    chk_if("fa5", 0, 32'h0, NOP);
    drive(0, 0, 0, '0, 0, '0);             chk_req("fa6", 1, 32'h200);
    check("fa6_valid", if_id_valid, 1'b0);
    check("fa6_instr", if_id_instr, NOP);
    drive(0, 0, 0, '0, 1, 32'h1234_5678);  chk_req("fa7", 1, 32'h200);
    drive(0, 0, 0, '0, 0, '0);             chk_req("fa8", 1, 32'h204);
    chk_if("fa8", 1, 32'h200, 32'h1234_5678);

    // ---------------- reset in DISCARD, and reset with a response in FETCH ----------------
    do_reset();
    drive(0, 0, 1, 32'h400, 0, '0);        chk_req("rb0", 1, 32'h60);
    drive(0, 0, 0, '0, 0, '0);             chk_req("rb1", 1, 32'h60);
    drive(1, 0, 0, '0, 1, 32'hBAD0_0BAD);  check("rb2_read", bus.imem_read, 1'b0);
    drive(0, 0, 0, '0, 0, '0);             chk_req("rb3", 1, 32'h60);
    chk_if("rb3", 0, 32'h0, NOP);
    drive(0, 0, 0, '0, 1, 32'h7777_0001);  chk_req("rb4", 1, 32'h60);
    drive(0, 0, 0, '0, 0, '0);             chk_req("rb5", 1, 32'h64);
    chk_if("rb5", 1, 32'h60, 32'h7777_0001);
    drive(1, 0, 0, '0, 1, 32'hBAD0_0BAD);  check("rb6_read", bus.imem_read, 1'b0);
    drive(0, 0, 0, '0, 0, '0);             chk_req("rb7", 1, 32'h60);
    chk_if("rb7", 0, 32'h0, NOP);

    // ---------------- randomized run against fetch-stream model ----------------
    do_reset();
    exp_next  = 32'h60;
    p_stall   = 1'b0;
    p_flush   = 1'b0;
    p_pending = 1'b0;
    p_valid   = 1'b0;
    p_addr    = '0;
    p_pc      = '0;
    p_instr   = NOP;
    mem_wait  = 0;
    consumed  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF4 + 32'($urandom_range(0, 7));
      else redirect_pc = $urandom;
      if (bus.imem_read) begin
        if (mem_wait == 0) begin
          bus.imem_resp  = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_address);
          mem_wait       = $urandom_range(0, 2);
        end else begin
          bus.imem_resp  = 1'b0;
          bus.imem_rdata = $urandom;
          mem_wait--;
        end
      end else begin
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = $urandom;
      end
      #1;

      // An invalid IF/ID carries NOP; a valid one carries the word stored at its PC.
      if (if_id_valid) check("rnd_instr", if_id_instr, mem_word(if_id_pc));
      else check("rnd_nop", if_id_instr, NOP);

      if (p_flush) begin
        check("rnd_flush_valid", if_id_valid, 1'b0);
        check("rnd_flush_pc", if_id_pc, 32'h0);
      end else if (p_stall) begin
        check("rnd_stall_valid", if_id_valid, p_valid);
        check("rnd_stall_pc", if_id_pc, p_pc);
        check("rnd_stall_instr", if_id_instr, p_instr);
      end

      // A request not yet answered must stay up at the same address.
      if (p_pending) begin
        check("rnd_req_held", bus.imem_read, 1'b1);
        check("rnd_req_addr", bus.imem_address, p_addr);
      end

      // Decode consumes IF/ID when not stalled: the stream must be sequential from the last target.
      if (!flush && !stall && if_id_valid) begin
        check("rnd_order", if_id_pc, exp_next);
        exp_next = exp_next + 32'd4;
        consumed++;
      end
      if (flush) exp_next = {redirect_pc[31:2], 2'b00};

      p_stall   = stall;
      p_flush   = flush;
      p_valid   = if_id_valid;
      p_pc      = if_id_pc;
      p_instr   = if_id_instr;
      p_pending = bus.imem_read && !bus.imem_resp;
      p_addr    = bus.imem_address;
    end
    check("rnd_progress", 32'(consumed > 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage RV32I pipeline. It owns the PC and the instruction-memory read handshake, and it produces the IF/ID pipeline register consumed by decode and the load-use hazard check. It stalls on the decode-side bubble/stall and redirects on taken branches and jumps from EX. It also holds one skid entry, so that a response arriving during a stall is never lost.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0060`: PC fetched first after reset.

**Ports**
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold IF/ID and PC. This is the hazard bubble OR-ed with downstream memory stalls.
- `flush` in 1: taken branch/jump resolved in EX; discard all fetched work.
- `redirect_pc` in 32: target for `flush`; bits [1:0] are forced to 0.
- `imem_read` out 1: read request; held high until `imem_resp`.
- `imem_address` out 32: read address; stable while `imem_read` is high.
- `imem_resp` in 1: read data valid, one cycle.
- `imem_rdata` in 32: instruction word.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_instr` out 32: IF/ID instruction; NOP `32'h0000_0013` when invalid.

## Operation

**State machine**
- `FETCH`:
  - `imem_read`=1, `imem_address`=`pc`.
  - On `imem_resp` with no flush: `pc` <= `pc`+4 (mod 2^32).
  - If `stall`=0: IF/ID <= {1, pc, rdata}.
  - If `stall`=1: skid <= {pc, rdata}, go `HOLD`.
- `HOLD`:
  - `imem_read`=0; the skid is full.
  - When `stall`=0: IF/ID <= skid, clear skid, go `FETCH`.
- `DISCARD`:
  - `imem_read`=1, `imem_address`=`stale_pc` (the address of the abandoned request).
  - On `imem_resp`: drop the data, go `FETCH`; `pc` already holds the redirect target.

**IF/ID update when `stall`=0 and no response is loaded**
- `if_id_valid` <= 0 and `if_id_instr` <= NOP. This is a fetch bubble.

**Flush** (priority over `stall` and `imem_resp`)
- IF/ID <= {0, 0, NOP}; skid cleared; `pc` <= `redirect_pc & ~3`.
- In `FETCH` with `imem_resp`=0: `stale_pc` <= `pc`, go `DISCARD`.
- In `FETCH` with `imem_resp`=1: the response is dropped; stay `FETCH`.
- In `HOLD`: go `FETCH`.
- In `DISCARD`: stay `DISCARD` (or go `FETCH` if `imem_resp`=1); `stale_pc` is unchanged.

**Reset values**
- state `FETCH`, `pc`=`RESET_PC`.
- `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=NOP.
- Skid empty, `stale_pc`=0.
- `imem_read` is forced to 0 in any cycle where `rst`=1.
- Reset mid-request abandons the outstanding read. Any `imem_resp` in the cycle `rst` is asserted is ignored.

## Timing

- `imem_read`/`imem_address` are combinational from state and `pc`. IF/ID outputs are registered.
- Latency: a response accepted in cycle N is visible on IF/ID in cycle N+1.
- Throughput: one instruction per cycle with single-cycle memory; the next request issues in the same cycle the `pc` update is visible.
- `HOLD` release: IF/ID is loaded from the skid at the edge ending the first `stall`=0 cycle. The request resumes in the following cycle, which costs one fetch-bubble cycle.
- Flush: the first correct-path request issues the cycle after flush from `FETCH`/`HOLD`, or the cycle after the stale response from `DISCARD`.
- Simultaneous `stall` and `flush`: the flush wins and IF/ID is cleared.
- `pc` wraps from `32'hFFFF_FFFC` to 0 without a flag.

## Structure

- In `rv32i_types`:
  - `NOP_INSTR` (`32'h0000_0013`), shared with the ID/EX bubble insertion.
  - `RESET_PC_DEFAULT`.
  - The `fetch_state_t` enum {FETCH, HOLD, DISCARD}, so debug monitors can decode it.
- One sub-module, `pc_register`: a 32-bit loadable register with synchronous reset to a parameter value. It is reused by any later branch-predictor PC logic.

## Test plan

- **Reset then single-cycle memory.** Release `rst`, `imem_resp` every cycle, `imem_rdata`=A,B,C.
  - Required: addresses 0x60, 0x64, 0x68 on consecutive cycles.
  - Required: IF/ID shows (0x60,A), (0x64,B), (0x68,C), each one cycle after its response.
- **Stall while a response arrives.** `stall`=1 in the cycle the response for 0x64 returns, held 3 cycles.
  - Required: IF/ID holds (0x60,A) through the stall; `imem_read`=0 in `HOLD`.
  - Required: after release, IF/ID = (0x64,B), then the next request is at 0x68.
- **Flush with a request outstanding.** 3-cycle memory latency, `flush`=1 with `redirect_pc`=0x203 one cycle into the request for 0x64.
  - Required: `imem_address` stays 0x64 until its response, and that data never reaches IF/ID.
  - Required: the next request is at 0x200; `if_id_valid`=0 meanwhile.
- **Flush coincident with response and stall.** `flush`, `stall` and `imem_resp` all high in one cycle.
  - Required: IF/ID = {0, 0, NOP}; the next address is the redirect target.
- **Reset mid-request.** Assert `rst` during the `DISCARD` state.
  - Required: `imem_read`=0 while `rst` is high; state returns to `FETCH` at 0x60; the late `imem_resp` is ignored.
